uart_hex_parser: RTL
====================

# uart_hex_parser

Line parser between `uart_rx` and the display path. It consumes received bytes, accumulates ASCII hex digits into a binary word, and commits that word when a CR or LF arrives. Malformed lines are reported with an error pulse and discarded up to the next terminator. Its registered `o_data`/`o_vld` feed `hex_display`, or any consumer of a parsed value, in place of raw UART bytes.

## Interface
- `NDIGITS`, default 4: maximum hex digits per line. Output width is 4*NDIGITS.
- `clk`, input, 1: system clock (50 MHz on board).
- `rst`, input, 1: reset, asynchronous and active-high.
- `i_data`, input, 8: received byte from `uart_rx`.
- `i_vld`, input, 1: byte strobe. Each cycle with `i_vld`=1 delivers exactly one byte. Back-to-back strobes are legal.
- `o_data`, output, 4*NDIGITS: last committed value, held between commits.
- `o_vld`, output, 1: one-cycle pulse when `o_data` is updated.
- `o_err`, output, 1: one-cycle pulse when a line is rejected.
- `o_busy`, output, 1: high when a line is partially received (state != IDLE).

## Operation
- Byte classes:
  - Digit: `0x30`–`0x39` maps to 0–9; `0x41`–`0x46` and `0x61`–`0x66` map to 10–15.
  - Terminator: `0x0D` or `0x0A`.
  - Everything else is invalid.
- Internal state:
  - Accumulator `acc`, 4*NDIGITS bits.
  - Digit counter `cnt`, 0..NDIGITS, width clog2(NDIGITS+1).
  - FSM with states IDLE, ACCUM, DISCARD.
- IDLE:
  - Digit: `acc` <= digit (zero-extended), `cnt` <= 1, go to ACCUM.
  - Terminator: ignored, stay in IDLE. This makes CRLF and empty lines produce no output.
  - Invalid byte: pulse `o_err`, go to DISCARD.
- ACCUM:
  - Digit with `cnt` < NDIGITS: `acc` <= {acc[4*NDIGITS-5:0], digit}, `cnt`++.
  - Digit with `cnt` == NDIGITS (overflow): pulse `o_err`, go to DISCARD.
  - Terminator: `o_data` <= `acc`, pulse `o_vld`, go to IDLE.
  - Invalid byte: pulse `o_err`, go to DISCARD.
- DISCARD:
  - Terminator: go to IDLE, no output pulse.
  - All other bytes: ignored, no further `o_err`. Exactly one `o_err` per rejected line.
- Fewer than NDIGITS digits are right-aligned and zero-extended: "1F" gives 0x001F.
- The first digit is most significant.
- Cycles with `i_vld`=0 change nothing. No timeout.

## Timing
- Reset values: state IDLE, `acc` 0, `cnt` 0, `o_data` 0, `o_vld` 0, `o_err` 0, `o_busy` 0.
- Asserting `rst` mid-line drops the partial line with no pulses. After release, the parser starts in IDLE.
- All outputs are registered. `o_vld` or `o_err` goes high in the cycle after the clock edge that sampled the triggering `i_vld`, for exactly one cycle.
- `o_data` changes in the same cycle `o_vld` rises and is stable thereafter until the next commit.
- `o_vld` and `o_err` are never high in the same cycle.
- `o_busy` reflects the state register, so it updates one cycle after the accepting edge.
- Throughput is one byte per cycle sustained. A terminator immediately followed by a digit on the next cycle commits the old line and starts the new one without loss.

## Test plan
- Reset, then send "1F\r" (`0x31`,`0x46`,`0x0D`), one byte every 250 cycles -> one `o_vld` pulse, `o_data`=0x001F, `o_err` never high, `o_busy` 0 afterwards.
- Send "aBcD\n" then "\r" -> `o_data`=0xABCD with a single `o_vld` pulse; the extra `\r` produces nothing.
- Send "12345\r" (NDIGITS=4) -> `o_err` pulses once, on the 5th digit; no `o_vld`; `o_data` keeps its prior value. Then "7\r" -> `o_data`=0x0007.
- Send "1G2\r" -> a single `o_err` on 'G'; '2' and `\r` are ignored; `o_busy` returns to 0 after `\r`.
- Back-to-back bytes on consecutive cycles: "AB\r" then "CD\r" -> two `o_vld` pulses, values 0x00AB then 0x00CD.
- Send "12", assert `rst` for 3 cycles, release, send "3\r" -> `o_data`=0x0003; no pulses during or after reset except that commit.

Source files
------------

// File: rtl/uart_hex_parser.sv
// Parses ASCII hex lines from uart_rx into a binary word, committed on CR or LF.
// Latency: o_vld/o_err pulse one cycle after the edge sampling the deciding byte.
// Backpressure: none; accepts one byte per cycle sustained, never stalls.
module uart_hex_parser #(
    parameter int NDIGITS = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             i_data,
    input  logic                   i_vld,
    output logic [4*NDIGITS-1:0]   o_data,
    output logic                   o_vld,
    output logic                   o_err,
    output logic                   o_busy
);
    localparam int W  = 4 * NDIGITS;
    localparam int CW = $clog2(NDIGITS + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t          state, state_n;
    logic [W-1:0]    acc, acc_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [W-1:0]    data_n;
    logic            vld_n, err_n;

    logic            is_dig, is_term;
    logic [3:0]      dig;

    // Letters A-F/a-f share low nibbles 1..6, so value is nibble + 9.
    always_comb begin
        is_dig  = 1'b0;
        dig     = 4'd0;
        is_term = (i_data == 8'h0D) || (i_data == 8'h0A);
        if (i_data >= 8'h30 && i_data <= 8'h39) begin
            is_dig = 1'b1;
            dig    = i_data[3:0];
        end else if ((i_data >= 8'h41 && i_data <= 8'h46) ||
                     (i_data >= 8'h61 && i_data <= 8'h66)) begin
            is_dig = 1'b1;
            dig    = i_data[3:0] + 4'd9;
        end
    end

    always_comb begin
        state_n = state;
        acc_n   = acc;
        cnt_n   = cnt;
        data_n  = o_data;
        vld_n   = 1'b0;
        err_n   = 1'b0;
        if (i_vld) begin
            case (state)
                IDLE: begin
                    if (is_dig) begin
                        acc_n   = W'(dig);
                        cnt_n   = CW'(1);
                        state_n = ACCUM;
                    end else if (!is_term) begin
                        err_n   = 1'b1;
                        state_n = DISCARD;
                    end
                end
                ACCUM: begin
                    if (is_term) begin
                        data_n  = acc;
                        vld_n   = 1'b1;
                        state_n = IDLE;
                    end else if (is_dig && cnt < CW'(NDIGITS)) begin
                        acc_n = (acc << 4) | W'(dig);
                        cnt_n = cnt + CW'(1);
                    end else begin
                        err_n   = 1'b1;
                        state_n = DISCARD;
                    end
                end
                DISCARD: begin
                    if (is_term) begin
                        state_n = IDLE;
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            acc    <= '0;
            cnt    <= '0;
            o_data <= '0;
            o_vld  <= 1'b0;
            o_err  <= 1'b0;
            o_busy <= 1'b0;
        end else begin
            state  <= state_n;
            acc    <= acc_n;
            cnt    <= cnt_n;
            o_data <= data_n;
            o_vld  <= vld_n;
            o_err  <= err_n;
            o_busy <= (state_n != IDLE);
        end
    end
endmodule
